// File: rtl/seqdet_pkg.sv
// Shared types and default constants for the serial sequence detector.
package seqdet_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_ARMED = 2'b10
  } state_t;

  localparam int          N_DEF       = 4;
  localparam logic [3:0]  PATTERN_DEF = 4'b1011;
  localparam int          CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial N-bit pattern detector with registered match pulse and
// saturating match counter. Define SEQDET_STICKY_EN to add the sticky 'seen' output.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int           N       = N_DEF,
  parameter logic [N-1:0] PATTERN = N'(PATTERN_DEF),
  parameter int           OVERLAP = 1,
  parameter int           CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
`ifdef SEQDET_STICKY_EN
  ,
  output logic             seen
`endif
);

  localparam int FW = $clog2(N + 1);

  state_t         state;
  logic [N-1:0]   hist;
  logic [FW-1:0]  fill;
  logic [N-1:0]   hist_nxt;
  logic [FW-1:0]  fill_nxt;
  logic           match;

  // Once armed the history is full, so fill simply holds at N.
  always_comb begin
    hist_nxt = (hist << 1) | N'(x);
    fill_nxt = (state == S_ARMED) ? fill : fill + FW'(1);
    match    = x_valid && (hist_nxt == PATTERN) && (fill_nxt == FW'(N));
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state <= S_IDLE;
      hist  <= '0;
      fill  <= '0;
      y     <= 1'b0;
    end else begin
      y <= match;
      if (x_valid) begin
        if (match && (OVERLAP == 0)) begin
          // Non-overlapping: discard history so the next match needs N fresh bits.
          state <= S_IDLE;
          hist  <= '0;
          fill  <= '0;
        end else begin
          hist  <= hist_nxt;
          fill  <= fill_nxt;
          state <= (fill_nxt == FW'(N)) ? S_ARMED : S_FILL;
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (match),
    .count (match_count),
    .sat   (cnt_sat)
  );

`ifdef SEQDET_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      seen <= 1'b0;
    end else if (match) begin
      seen <= 1'b1;
    end
  end
`endif

endmodule
